// File: rtl/fpu_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = a - b) with valid/ready handshakes.
// Optional debug tap ports are enabled by defining FPU_SUB_DEBUG_TAP_EN.
module fpu_sub_seq #(
  parameter logic [31:0] QNAN_VAL = 32'h7FC00000,
  parameter bit          FTZ      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        error,
  output logic        overflow,
  output logic        underflow
`ifdef FPU_SUB_DEBUG_TAP_EN
  ,
  output logic [2:0]  dbg_state,
  output logic [7:0]  dbg_aligned_exp,
  output logic [23:0] dbg_aligned_mant_a,
  output logic [23:0] dbg_aligned_mant_b,
  output logic [26:0] dbg_sum,
  output logic [9:0]  dbg_norm_exp
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state, state_next;

  logic [31:0] op_a, op_b;
  logic        big_sign, eff_sub;
  logic [7:0]  big_exp;
  logic [26:0] big_mant, small_mant;
  logic [27:0] sum;
  logic [26:0] norm_mant;
  logic signed [9:0] norm_exp;
  logic        norm_zero;
  logic [31:0] res_q;
  logic        err_q, ovf_q, unf_q;

  logic transfer;
  assign in_ready = (state == S_IDLE) && !rst;
  assign transfer = in_valid && in_ready;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // Operand classification; op_b already holds the negated subtrahend.
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  assign a_nan  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
  assign a_inf  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
  assign a_zero = (op_a[30:23] == 8'h00) && (FTZ || (op_a[22:0] == 23'd0));
  assign b_nan  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
  assign b_inf  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
  assign b_zero = (op_b[30:23] == 8'h00) && (FTZ || (op_b[22:0] == 23'd0));

  logic        bypass;
  logic [31:0] byp_res;
  logic        byp_err;

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    bypass  = 1'b1;
    byp_res = 32'd0;
    byp_err = 1'b0;
    if (a_nan || b_nan) begin
      byp_res = QNAN_VAL;
      byp_err = 1'b1;
    end else if (a_inf && b_inf && (op_a[31] != op_b[31])) begin
      byp_res = QNAN_VAL;
      byp_err = 1'b1;
    end else if (a_inf) begin
      byp_res = op_a;
    end else if (b_inf) begin
      byp_res = op_b;
    end else if (a_zero && b_zero) begin
      byp_res = {op_a[31] & op_b[31], 31'd0};
    end else if (a_zero) begin
      byp_res = op_b;
    end else if (b_zero) begin
      byp_res = op_a;
    end else if ((op_a[30:0] == op_b[30:0]) && (op_a[31] != op_b[31])) begin
      byp_res = 32'd0;
    end else begin
      bypass = 1'b0;
    end
  end

  logic        a_big;
  logic [31:0] big_op, small_op;
  logic [7:0]  big_e, small_e, exp_diff;
  logic [26:0] small_ext, small_shift, small_next, big_next;
  logic        small_sticky;

  always_comb begin
    a_big        = op_a[30:0] >= op_b[30:0];
    big_op       = a_big ? op_a : op_b;
    small_op     = a_big ? op_b : op_a;
    big_e        = (big_op[30:23] == 8'd0) ? 8'd1 : big_op[30:23];
    small_e      = (small_op[30:23] == 8'd0) ? 8'd1 : small_op[30:23];
    exp_diff     = big_e - small_e;
    big_next     = {|big_op[30:23], big_op[22:0], 3'b000};
    small_ext    = {|small_op[30:23], small_op[22:0], 3'b000};
    small_shift  = 27'd0;
    small_sticky = 1'b1;
    if (exp_diff <= 8'd26) begin
      small_shift  = small_ext >> exp_diff[4:0];
      small_sticky = |(small_ext & ~({27{1'b1}} << exp_diff[4:0]));
    end
    small_next = {small_shift[26:1], small_shift[0] | small_sticky};
  end

  logic [27:0] sum_next;
  assign sum_next = eff_sub ? ({1'b0, big_mant} - {1'b0, small_mant})
                            : ({1'b0, big_mant} + {1'b0, small_mant});

  logic [4:0]        lz;
  logic [26:0]       norm_mant_next;
  logic signed [9:0] norm_exp_next;

  always_comb begin
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm_mant_next = {sum[27:2], sum[1] | sum[0]};
      norm_exp_next  = $signed({2'b00, big_exp}) + 10'sd1;
    end else begin
      norm_mant_next = sum[26:0] << lz;
      norm_exp_next  = $signed({2'b00, big_exp}) - $signed({5'b00000, lz});
    end
  end

  logic              round_up;
  logic [24:0]       rnd;
  logic signed [9:0] exp_r;
  logic [22:0]       mant_r;
  logic [31:0]       rnd_res;
  logic              rnd_ovf, rnd_unf;

  always_comb begin
    round_up = norm_mant[2] & (norm_mant[1] | norm_mant[0] | norm_mant[3]);
    rnd      = {1'b0, norm_mant[26:3]} + {24'd0, round_up};
    exp_r    = norm_exp + (rnd[24] ? 10'sd1 : 10'sd0);
    mant_r   = rnd[24] ? rnd[23:1] : rnd[22:0];
    rnd_res  = {big_sign, exp_r[7:0], mant_r};
    rnd_ovf  = 1'b0;
    rnd_unf  = 1'b0;
    if (norm_zero) begin
      rnd_res = 32'd0;
    end else if (exp_r >= 10'sd255) begin
      rnd_res = {big_sign, 8'hFF, 23'd0};
      rnd_ovf = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      rnd_res = {big_sign, 31'd0};
      rnd_unf = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (transfer) state_next = S_UNPACK;
      S_UNPACK: state_next = bypass ? S_DONE : S_ALIGN;
      S_ALIGN:  state_next = S_ADDSUB;
      S_ADDSUB: state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE:   if (out_valid && out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      big_sign   <= 1'b0;
      eff_sub    <= 1'b0;
      big_exp    <= 8'd0;
      big_mant   <= 27'd0;
      small_mant <= 27'd0;
      sum        <= 28'd0;
      norm_mant  <= 27'd0;
      norm_exp   <= 10'sd0;
      norm_zero  <= 1'b0;
      res_q      <= 32'd0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (transfer) begin
          op_a <= a;
          op_b <= {~b[31], b[30:0]};
        end
        S_UNPACK: if (bypass) begin
          res_q <= byp_res;
          err_q <= byp_err;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
        end
        S_ALIGN: begin
          big_sign   <= big_op[31];
          eff_sub    <= op_a[31] ^ op_b[31];
          big_exp    <= big_e;
          big_mant   <= big_next;
          small_mant <= small_next;
        end
        S_ADDSUB: sum <= sum_next;
        S_NORM: begin
          norm_mant <= norm_mant_next;
          norm_exp  <= norm_exp_next;
          norm_zero <= (sum == 28'd0);
        end
        S_ROUND: begin
          res_q <= rnd_res;
          err_q <= 1'b0;
          ovf_q <= rnd_ovf;
          unf_q <= rnd_unf;
        end
        default: ;
      endcase
    end
  end

  // The output register loads in the first DONE cycle and then holds until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
      error     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if ((state == S_DONE) && !out_valid) begin
      out_valid <= 1'b1;
      result    <= res_q;
      error     <= err_q;
      overflow  <= ovf_q;
      underflow <= unf_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FPU_SUB_DEBUG_TAP_EN
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || transfer) begin
      dbg_aligned_exp    <= 8'd0;
      dbg_aligned_mant_a <= 24'd0;
      dbg_aligned_mant_b <= 24'd0;
      dbg_sum            <= 27'd0;
      dbg_norm_exp       <= 10'd0;
    end else begin
      if (state == S_ALIGN) begin
        dbg_aligned_exp    <= big_e;
        dbg_aligned_mant_a <= big_next[26:3];
        dbg_aligned_mant_b <= small_next[26:3];
      end
      if (state == S_ADDSUB) dbg_sum      <= sum_next[26:0];
      if (state == S_NORM)   dbg_norm_exp <= norm_exp_next;
    end
  end
`endif

endmodule
